// File: rtl/pkt_recv_dma_if.sv
// Flit stream, packet-memory write port and CPU handshake of the receive DMA.
// The slave modport is the DMA's view; master is the view of its environment.
interface pkt_recv_dma_if #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH       = 16
);
  logic [MEMORY_BUS_WIDTH-1:0] flit_in;
  logic                        flit_valid;
  logic                        flit_ready;
  logic                        mem_enable;
  logic                        mem_wb;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [MEMORY_BUS_WIDTH-1:0] mem_data;
  logic                        pkt_ready;
  logic                        pkt_ack;
  logic [MEMORY_BUS_WIDTH-1:0] pkt_header;

  modport slave (
    input  flit_in, flit_valid, pkt_ack,
    output flit_ready, mem_enable, mem_wb, mem_addr, mem_data,
           pkt_ready, pkt_header
  );

  modport master (
    output flit_in, flit_valid, pkt_ack,
    input  flit_ready, mem_enable, mem_wb, mem_addr, mem_data,
           pkt_ready, pkt_header
  );
endinterface

// File: rtl/pkt_recv_dma.sv
// Receive DMA: writes packet payload into a fixed buffer, then the length word.
// Optional macro PKT_RECV_DROP_CNT_EN adds a saturating dropped-packet counter.
module pkt_recv_dma #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH       = 16,
  parameter int BASE_ADDR        = 0,
  parameter int MAX_LEN          = 64
) (
  input  logic                clock,
  input  logic                reset,
  pkt_recv_dma_if.slave       bus
`ifdef PKT_RECV_DROP_CNT_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    DROP,
    WRLEN,
    WAIT_ACK
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [15:0]                 r_cnt;
  logic [15:0]                 w_cnt_next;
  logic [15:0]                 r_len;
  logic [15:0]                 w_len_next;
  logic [MEMORY_BUS_WIDTH-1:0] r_header;
  logic [MEMORY_BUS_WIDTH-1:0] w_header_next;

  logic                        w_flit_ready;
  logic                        w_accept;
  logic                        w_last;
  logic [15:0]                 w_len_in;
  logic                        w_mem_en;
  logic [ADDR_WIDTH-1:0]       w_mem_addr;
  logic [MEMORY_BUS_WIDTH-1:0] w_mem_data;
  logic                        w_pkt_ready;

  assign w_len_in     = bus.flit_in[15:0];
  assign w_flit_ready = !reset && (r_state inside {IDLE, LEN, PAYLOAD, DROP});
  assign w_accept     = bus.flit_valid && w_flit_ready;
  // Only meaningful in PAYLOAD/DROP, where r_len is at least 1.
  assign w_last       = (r_cnt == r_len - 16'd1);

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state  = r_state;
    w_cnt_next    = r_cnt;
    w_len_next    = r_len;
    w_header_next = r_header;
    w_mem_en      = 1'b0;
    w_mem_addr    = '0;
    w_mem_data    = '0;
    w_pkt_ready   = 1'b0;

    // A reset cycle issues no write and reports no packet, whatever the state.
    if (!reset) begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_header_next = bus.flit_in;
            w_next_state  = LEN;
          end
        end

        LEN: begin
          if (w_accept) begin
            w_len_next = w_len_in;
            w_cnt_next = '0;
            if ({16'd0, w_len_in} > 32'(MAX_LEN)) begin
              w_next_state = DROP;
            end else if (w_len_in == 16'd0) begin
              w_next_state = WRLEN;
            end else begin
              w_next_state = PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (w_accept) begin
            w_mem_en   = 1'b1;
            w_mem_addr = ADDR_WIDTH'(BASE_ADDR + 1) + ADDR_WIDTH'(r_cnt);
            w_mem_data = bus.flit_in;
            w_cnt_next = r_cnt + 16'd1;
            if (w_last) begin
              w_next_state = WRLEN;
            end
          end
        end

        DROP: begin
          if (w_accept) begin
            w_cnt_next = r_cnt + 16'd1;
            if (w_last) begin
              w_next_state = IDLE;
            end
          end
        end

        WRLEN: begin
          w_mem_en     = 1'b1;
          w_mem_addr   = ADDR_WIDTH'(BASE_ADDR);
          w_mem_data   = MEMORY_BUS_WIDTH'(r_len);
          w_next_state = WAIT_ACK;
        end

        WAIT_ACK: begin
          w_pkt_ready = 1'b1;
          if (bus.pkt_ack) begin
            w_next_state = IDLE;
          end
        end

        default: w_next_state = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_header <= '0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_cnt_next;
      r_len    <= w_len_next;
      r_header <= w_header_next;
    end
  end

`ifdef PKT_RECV_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if ((r_state == DROP) && (w_next_state == IDLE)
                 && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign bus.flit_ready = w_flit_ready;
  assign bus.mem_enable = w_mem_en;
  assign bus.mem_wb     = w_mem_en;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_data   = w_mem_data;
  assign bus.pkt_ready  = w_pkt_ready;
  assign bus.pkt_header = r_header;

endmodule

// File: tb/tb_pkt_recv_dma.sv
// Directed bench for pkt_recv_dma: a per-cycle vector table plus hand-written
// sequences for drop, maximum length and mid-packet reset.
module tb_pkt_recv_dma;
  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int BASE = 16;
  localparam int MAXL = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pkt_recv_dma_if #(.MEMORY_BUS_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef PKT_RECV_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  pkt_recv_dma #(
    .MEMORY_BUS_WIDTH(DW),
    .ADDR_WIDTH      (AW),
    .BASE_ADDR       (BASE),
    .MAX_LEN         (MAXL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
`ifdef PKT_RECV_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: commits writes at the rising edge, as the real memory does.
  logic [DW-1:0] mem_model [0:255];
  int unsigned   wr_total    = 0;
  int unsigned   wr_base_cnt = 0;

  always @(posedge clock) begin
    if (bus.mem_enable && bus.mem_wb) begin
      mem_model[bus.mem_addr[7:0]] <= bus.mem_data;
      wr_total <= wr_total + 1;
      if (bus.mem_addr == AW'(BASE)) wr_base_cnt <= wr_base_cnt + 1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        ack;
    logic        fr;
    logic        men;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        pr;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] d, logic a, logic fr,
                              logic men, logic [15:0] ad, logic [31:0] wd, logic pr);
    vec_t t;
    t.valid = v; t.data = d; t.ack = a; t.fr = fr;
    t.men = men; t.addr = ad; t.wdata = wd; t.pr = pr;
    return t;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic a);
    bus.flit_valid = v;
    bus.flit_in    = d;
    bus.pkt_ack    = a;
  endtask

  // Present one flit for one cycle; caller guarantees flit_ready is high.
  task automatic send(input logic [31:0] d);
    drive(1'b1, d, 1'b0);
    @(negedge clock);
  endtask

  task automatic ack_pulse();
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    drive(1'b0, 32'h0, 1'b0);
  endtask

  vec_t        vecs [27];
  int unsigned wr_before;
  int unsigned base_before;
  int          fr_low;

  initial begin
    vecs[0]  = mk(1, 32'hA5,   0, 1, 0, 0,  0,      0);
    vecs[1]  = mk(1, 32'h3,    0, 1, 0, 0,  0,      0);
    vecs[2]  = mk(1, 32'h11,   0, 1, 1, 17, 32'h11, 0);
    vecs[3]  = mk(1, 32'h22,   0, 1, 1, 18, 32'h22, 0);
    vecs[4]  = mk(1, 32'h33,   0, 1, 1, 19, 32'h33, 0);
    vecs[5]  = mk(1, 32'h44,   0, 0, 1, 16, 32'h3,  0);
    vecs[6]  = mk(1, 32'h44,   0, 0, 0, 0,  0,      1);
    vecs[7]  = mk(1, 32'h44,   0, 0, 0, 0,  0,      1);
    vecs[8]  = mk(1, 32'h44,   1, 0, 0, 0,  0,      1);
    vecs[9]  = mk(1, 32'h5A,   0, 1, 0, 0,  0,      0);
    vecs[10] = mk(1, 32'h0,    0, 1, 0, 0,  0,      0);
    vecs[11] = mk(0, 32'h0,    0, 0, 1, 16, 32'h0,  0);
    vecs[12] = mk(0, 32'h0,    0, 0, 0, 0,  0,      1);
    vecs[13] = mk(0, 32'h0,    1, 0, 0, 0,  0,      1);
    vecs[14] = mk(0, 32'h0,    1, 1, 0, 0,  0,      0);
    vecs[15] = mk(1, 32'hC3,   0, 1, 0, 0,  0,      0);
    vecs[16] = mk(1, 32'h4,    0, 1, 0, 0,  0,      0);
    vecs[17] = mk(0, 32'hDEAD, 0, 1, 0, 0,  0,      0);
    vecs[18] = mk(1, 32'h101,  0, 1, 1, 17, 32'h101, 0);
    vecs[19] = mk(0, 32'h0,    0, 1, 0, 0,  0,      0);
    vecs[20] = mk(0, 32'h0,    0, 1, 0, 0,  0,      0);
    vecs[21] = mk(1, 32'h102,  0, 1, 1, 18, 32'h102, 0);
    vecs[22] = mk(1, 32'h103,  0, 1, 1, 19, 32'h103, 0);
    vecs[23] = mk(0, 32'h0,    0, 1, 0, 0,  0,      0);
    vecs[24] = mk(1, 32'h104,  0, 1, 1, 20, 32'h104, 0);
    vecs[25] = mk(0, 32'h0,    0, 0, 1, 16, 32'h4,  0);
    vecs[26] = mk(0, 32'h0,    1, 0, 0, 0,  0,      1);

    // Reset held with valid asserted: nothing accepted, nothing written.
    drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    repeat (2) @(negedge clock);
    #1;
    check("rst.flit_ready", 32'(bus.flit_ready), 32'h0);
    check("rst.mem_enable", 32'(bus.mem_enable), 32'h0);
    check("rst.mem_wb",     32'(bus.mem_wb),     32'h0);
    check("rst.mem_addr",   32'(bus.mem_addr),   32'h0);
    check("rst.mem_data",   bus.mem_data,        32'h0);
    check("rst.pkt_ready",  32'(bus.pkt_ready),  32'h0);
    check("rst.pkt_header", bus.pkt_header,      32'h0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].ack);
      #1;
      check($sformatf("vec%0d.flit_ready", i), 32'(bus.flit_ready), 32'(vecs[i].fr));
      check($sformatf("vec%0d.mem_enable", i), 32'(bus.mem_enable), 32'(vecs[i].men));
      check($sformatf("vec%0d.mem_wb", i),     32'(bus.mem_wb),     32'(vecs[i].men));
      if (vecs[i].men) begin
        check($sformatf("vec%0d.mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].addr));
        check($sformatf("vec%0d.mem_data", i), bus.mem_data,      vecs[i].wdata);
      end
      check($sformatf("vec%0d.pkt_ready", i), 32'(bus.pkt_ready), 32'(vecs[i].pr));
      @(negedge clock);
    end
    drive(1'b0, 32'h0, 1'b0);
    #1;
    check("tbl.pkt_header", bus.pkt_header, 32'hC3);
    check("tbl.pkt_ready",  32'(bus.pkt_ready), 32'h0);

    // Oversized packet: drained with no memory traffic and no pkt_ready.
    wr_before = wr_total;
    fr_low    = 0;
    send(32'h77);
    send(32'(MAXL + 1));
    for (int i = 0; i < MAXL + 1; i++) begin
      drive(1'b1, 32'h2000 + 32'(i), 1'b0);
      #1;
      if (!bus.flit_ready) fr_low++;
      @(negedge clock);
    end
    drive(1'b0, 32'h0, 1'b0);
    #1;
    check("drop.flit_ready_low_cycles", 32'(fr_low), 32'h0);
    check("drop.writes", 32'(wr_total - wr_before), 32'h0);
    check("drop.idle_ready", 32'(bus.flit_ready), 32'h1);
    check("drop.pkt_ready",  32'(bus.pkt_ready),  32'h0);
    check("drop.pkt_header", bus.pkt_header,      32'h77);
`ifdef PKT_RECV_DROP_CNT_EN
    check("drop.drop_cnt", 32'(drop_cnt), 32'h1);
`endif
    // Next packet must start from IDLE: header, length 1, one payload.
    send(32'h88);
    send(32'h1);
    send(32'hAB);
    drive(1'b0, 32'h0, 1'b0);
    #1;
    check("post_drop.wrlen_en",  32'(bus.mem_enable), 32'h1);
    check("post_drop.wrlen_dat", bus.mem_data,        32'h1);
    check("post_drop.pkt_ready_early", 32'(bus.pkt_ready), 32'h0);
    @(negedge clock);
    #1;
    check("post_drop.pkt_ready", 32'(bus.pkt_ready), 32'h1);
    check("post_drop.payload",   mem_model[BASE + 1], 32'hAB);
    check("post_drop.header",    bus.pkt_header,      32'h88);
    ack_pulse();

    // Maximum length: last word lands at BASE+MAX_LEN.
    send(32'hBB);
    send(32'(MAXL));
    for (int i = 0; i < MAXL; i++) send(32'h1000 + 32'(i));
    drive(1'b0, 32'h0, 1'b0);
    #1;
    check("max.wrlen_addr", 32'(bus.mem_addr), 32'(BASE));
    check("max.wrlen_data", bus.mem_data,      32'(MAXL));
    check("max.pkt_ready_early", 32'(bus.pkt_ready), 32'h0);
    @(negedge clock);
    #1;
    check("max.pkt_ready",  32'(bus.pkt_ready), 32'h1);
    check("max.first_word", mem_model[BASE + 1],    32'h1000);
    check("max.last_word",  mem_model[BASE + MAXL], 32'h1000 + 32'(MAXL - 1));
    check("max.len_word",   mem_model[BASE],        32'(MAXL));
    ack_pulse();
    #1;
    check("max.ack_pkt_ready",  32'(bus.pkt_ready),  32'h0);
    check("max.ack_flit_ready", 32'(bus.flit_ready), 32'h1);

    // Reset after two of five payload flits: packet abandoned, BASE untouched.
    base_before = wr_base_cnt;
    send(32'h99);
    send(32'h5);
    send(32'h501);
    send(32'h502);
    reset = 1'b1;
    drive(1'b1, 32'h503, 1'b0);
    #1;
    check("midrst.flit_ready", 32'(bus.flit_ready), 32'h0);
    check("midrst.mem_enable", 32'(bus.mem_enable), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #1;
    check("midrst.pkt_ready",  32'(bus.pkt_ready),  32'h0);
    check("midrst.flit_ready", 32'(bus.flit_ready), 32'h1);
    check("midrst.base_writes", 32'(wr_base_cnt - base_before), 32'h0);
    send(32'hD1);
    send(32'h2);
    send(32'h7);
    send(32'h8);
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clock);
    #1;
    check("midrst.next_pkt_ready", 32'(bus.pkt_ready), 32'h1);
    check("midrst.next_w1",  mem_model[BASE + 1], 32'h7);
    check("midrst.next_w2",  mem_model[BASE + 2], 32'h8);
    check("midrst.next_len", mem_model[BASE],     32'h2);
    check("midrst.next_hdr", bus.pkt_header,      32'hD1);
    ack_pulse();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pkt_recv_dma.md
# pkt_recv_dma

Receive-side DMA engine feeding one port of the node's dual-port packet memory. Accepts a flit stream from the router's local output with a valid/ready handshake and writes each payload flit straight into a fixed receive buffer. When the packet is complete it writes the length word and raises `pkt_ready` to the CPU, back-pressuring the network until the CPU acknowledges. Oversized packets are drained and discarded without touching memory.

## Interface
- `MEMORY_BUS_WIDTH`, 32: flit and memory word width, ≥16.
- `ADDR_WIDTH`, 16: memory word-address width.
- `BASE_ADDR`, 0: word address of the receive buffer.
- `MAX_LEN`, 64: largest payload length accepted, in flits; buffer occupies `BASE_ADDR` .. `BASE_ADDR+MAX_LEN`.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `flit_in` in MEMORY_BUS_WIDTH: incoming flit.
- `flit_valid` in 1: `flit_in` valid.
- `flit_ready` out 1: block accepts flit this cycle.
- `mem_enable` out 1: memory port enable.
- `mem_wb` out 1: memory write strobe.
- `mem_addr` out ADDR_WIDTH: memory word address.
- `mem_data` out MEMORY_BUS_WIDTH: memory write data.
- `pkt_ready` out 1: complete packet in buffer.
- `pkt_ack` in 1: CPU releases buffer (single-cycle pulse).
- `pkt_header` out MEMORY_BUS_WIDTH: header flit of last accepted packet.

## Operation
- Packet format: flit 0 header, flit 1 length N = `flit_in[15:0]`, then N payload flits.
- Accept = `flit_valid && flit_ready` at a rising edge.
- FSM states: IDLE, LEN, PAYLOAD, DROP, WRLEN, WAIT_ACK.
- IDLE: on accept, latch `pkt_header`; go to LEN.
- LEN: on accept, latch N, clear the payload counter `cnt`. If N > MAX_LEN, go to DROP. If N == 0, go to WRLEN. Otherwise go to PAYLOAD.
- PAYLOAD: each accept writes `flit_in` to `BASE_ADDR+1+cnt` in the same cycle (combinational `mem_enable`/`mem_wb`/`mem_addr`/`mem_data`), then increments `cnt`. The accept with `cnt == N-1` goes to WRLEN.
- DROP: accept N flits with no memory access, then go to IDLE. `pkt_header` is still updated; `pkt_ready` is not raised.
- WRLEN: one cycle writing N (zero-extended) to `BASE_ADDR`, then go to WAIT_ACK.
- WAIT_ACK: `pkt_ready = 1`; on `pkt_ack`, go to IDLE.
- `flit_ready` = 1 in IDLE, LEN, PAYLOAD and DROP; 0 in WRLEN and WAIT_ACK. It does not depend on `flit_valid`.
- `mem_enable` and `mem_wb` are always equal. They are 0 except during PAYLOAD accepts and in WRLEN.
- `pkt_ack` outside WAIT_ACK is ignored.

## Timing
- Reset values: state IDLE, `pkt_ready` 0, `pkt_header` 0, `cnt` 0, `mem_enable`/`mem_wb` 0, `mem_addr` 0, `mem_data` 0.
- Reset takes priority in any state. In a reset cycle no memory write is issued and `flit_ready` = 0. A partially written packet is abandoned; the length word is not written.
- Payload write latency: 0. The write is presented in the accept cycle and committed by memory at the same edge.
- If the last payload flit is accepted at edge k: WRLEN occupies cycle k..k+1, and `pkt_ready` is 1 from edge k+1.
- `pkt_ack` sampled at edge a: `pkt_ready` is 0 and `flit_ready` is 1 from edge a.
- A gap in `flit_valid` stalls the FSM in place with no write issued.
- N == MAX_LEN is accepted; the last payload word lands at `BASE_ADDR+MAX_LEN`.

## Configuration
- `PKT_RECV_DROP_CNT_EN`: when defined, adds output `drop_cnt` (out, 16 bits, reset 0). It increments, saturating at 16'hFFFF, on the edge DROP returns to IDLE.
- When undefined, the port and counter do not exist; drop behaviour is otherwise identical.

## Test plan
- Reset, then header 0xA5, length 3, payload 0x11/0x22/0x33 back-to-back → writes to BASE+1..BASE+3, then 3 written to BASE; `pkt_ready` 1 two cycles after the last flit; `pkt_header` = 0xA5.
- `pkt_ready` high, `flit_valid` held 1 → `flit_ready` stays 0 and no writes occur; `pkt_ack` pulse → `pkt_ready` 0 and the next header is accepted the following cycle.
- Length MAX_LEN+1 (65) with 65 flits → no memory activity, `pkt_ready` stays 0, return to IDLE; `drop_cnt` = 1 when `PKT_RECV_DROP_CNT_EN` is defined.
- Length 0 → single write of 0 to BASE, then `pkt_ready`.
- Valid gaps between payload flits of a 4-flit packet → writes only on accept cycles, addresses BASE+1..BASE+4 with no skips.
- Reset asserted after 2 of 5 payload flits → `pkt_ready` 0, BASE untouched, next packet received correctly from IDLE.
